// File: rtl/spi_periph_pkg.sv
// Shared types and frame-layout helpers for the SPI register-file peripheral.
// Frames are [R/W][addr][data], MSB first; positions below index the full captured frame.
package spi_periph_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;

  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned rw_bit(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with edge detection on the
// two oldest stages so edges are only seen once the level is metastability-safe.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic counter_clock,
  input  logic rstn,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  // stage_q[0] is the newest sample, stage_q[SYNC_STAGES-1] the oldest.
  logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge counter_clock) begin
    if (!rstn) begin
      stage_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = ~stage_q[SYNC_STAGES-1] & stage_q[SYNC_STAGES-2];
  assign fall = stage_q[SYNC_STAGES-1] & ~stage_q[SYNC_STAGES-2];

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register bank to an SPI host.
// Optional read-back of registers over cipo is enabled by defining SPI_READBACK_EN.
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                         counter_clock,
  input  logic                         rstn,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W    = $clog2(FRAME_W + 2);
  localparam int unsigned RW_POS   = rw_bit(ADDR_W, DATA_W);
  localparam int unsigned ADDR_POS = addr_lsb(DATA_W);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] OVER_CNT  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(ADDR_W);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic copi_sync, copi_rise, copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .counter_clock (counter_clock),
    .rstn          (rstn),
    .din           (sclk),
    .sync          (sclk_sync),
    .rise          (sclk_rise),
    .fall          (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .counter_clock (counter_clock),
    .rstn          (rstn),
    .din           (ncs),
    .sync          (ncs_sync),
    .rise          (ncs_rise),
    .fall          (ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .counter_clock (counter_clock),
    .rstn          (rstn),
    .din           (copi),
    .sync          (copi_sync),
    .rise          (copi_rise),
    .fall          (copi_fall)
  );

  spi_state_t          state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [FRAME_W-1:0]  shift_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                sclk_rise_v;
  logic                frame_rw;
  logic [ADDR_W-1:0]   frame_addr;
  logic [DATA_W-1:0]   frame_data;
  logic                addr_ok;

  assign sclk_rise_v = sclk_rise & ~ncs_sync;
  assign shift_d     = {shift_q[FRAME_W-2:0], copi_sync};
  assign frame_rw    = shift_q[RW_POS];
  assign frame_addr  = shift_q[ADDR_POS +: ADDR_W];
  assign frame_data  = shift_q[DATA_LSB +: DATA_W];
  assign addr_ok     = 32'(frame_addr) < NUM_REGS;

  always_ff @(posedge counter_clock) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        SHIFT: begin
          // ncs rise wins over a coincident sclk rise: that last bit is dropped.
          if (ncs_rise) begin
            state_q <= DONE;
          end else if (sclk_rise_v) begin
            shift_q <= shift_d;
            if (bit_cnt_q != OVER_CNT) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (bit_cnt_q == FRAME_CNT) begin
            if (frame_rw && addr_ok) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (frame_addr == ADDR_W'(i)) regs_q[i] <= frame_data;
              end
              wr_stb  <= 1'b1;
              wr_addr <= frame_addr;
            end
          end else if (bit_cnt_q != '0) begin
            frame_err <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] rd_word;
  logic              cipo_q;

  // Header (R/W + addr) is complete in shift_d on the rise that brings bit_cnt to 1+ADDR_W.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_d[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge counter_clock) begin
    if (!rstn) begin
      shadow_q <= '0;
      cipo_q   <= 1'b0;
    end else if (state_q != SHIFT) begin
      shadow_q <= '0;
      cipo_q   <= 1'b0;
    end else if (!ncs_rise && sclk_rise_v && bit_cnt_q == HDR_CNT && !shift_d[ADDR_W]) begin
      shadow_q <= rd_word;
    end else if (sclk_fall && !ncs_sync) begin
      cipo_q   <= shadow_q[DATA_W-1];
      shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo    = cipo_q;
  assign cipo_oe = ~ncs_sync;

  logic unused_edges;
  assign unused_edges = ^{sclk_sync, copi_rise, copi_fall};
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;

  logic unused_edges;
  assign unused_edges = ^{sclk_sync, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph; define SPI_READBACK_EN to also exercise read-back.
module tb_spi_regfile_periph;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 5;
  localparam int unsigned SS = 3;

  logic counter_clock = 1'b0;
  logic rstn = 1'b0;
  logic sclk = 1'b0;
  logic ncs  = 1'b1;
  logic copi = 1'b0;
  logic cipo, cipo_oe, wr_stb, frame_err;
  logic [NR*DW-1:0] regs_flat;
  logic [AW-1:0]    wr_addr;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int stb_cyc = 0;
  int rise_cyc = 0;
  logic [AW-1:0]    stb_addr = '0;
  logic [NR*DW-1:0] stb_regs = '0;
  logic oe_all, oe_any, cipo_any;

  spi_regfile_periph #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .SYNC_STAGES (SS)
  ) dut (
    .counter_clock (counter_clock),
    .rstn          (rstn),
    .sclk          (sclk),
    .ncs           (ncs),
    .copi          (copi),
    .cipo          (cipo),
    .cipo_oe       (cipo_oe),
    .regs_flat     (regs_flat),
    .wr_stb        (wr_stb),
    .wr_addr       (wr_addr),
    .frame_err     (frame_err)
  );

  always #5 counter_clock = ~counter_clock;

  always @(posedge counter_clock) cyc <= cyc + 1;

  always @(negedge counter_clock) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_cyc  <= cyc;
      stb_addr <= wr_addr;
      stb_regs <= regs_flat;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // Clock nbits of word out MSB first; host samples cipo just before each rise.
  task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      repeat (8) @(negedge counter_clock);
      rx       = {rx[30:0], cipo};
      oe_all   = oe_all & cipo_oe;
      oe_any   = oe_any | cipo_oe;
      cipo_any = cipo_any | cipo;
      sclk = 1'b1;
      repeat (8) @(negedge counter_clock);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [31:0] word, input int nbits, output logic [31:0] rx);
    oe_all = 1'b1; oe_any = 1'b0; cipo_any = 1'b0;
    @(negedge counter_clock);
    ncs = 1'b0;
    repeat (8) @(negedge counter_clock);
    spi_bits(word, nbits, rx);
    repeat (8) @(negedge counter_clock);
    ncs = 1'b1;
    rise_cyc = cyc;
    repeat (12) @(negedge counter_clock);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge counter_clock);
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_flat); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (cipo !== 1'b0) begin errors++; $display("FAIL reset_cipo got %b want 0", cipo); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("FAIL reset_cipo_oe got %b want 0", cipo_oe); end
    rstn = 1'b1;
    repeat (4) @(negedge counter_clock);
  endtask

  task automatic test_write_reg0();
    logic [31:0] rx;
    int s0;
    s0 = stb_cnt;
    spi_xfer(32'h80A5, 16, rx);
    checks++; if (regs_flat !== 40'h00_0000_00A5) begin errors++; $display("FAIL w0_regs got %h want 00000000a5", regs_flat); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL w0_stb_count got %0d want 1", stb_cnt - s0); end
    checks++; if (stb_addr !== 7'd0) begin errors++; $display("FAIL w0_wr_addr got %h want 0", stb_addr); end
    checks++; if (stb_regs !== 40'h00_0000_00A5) begin errors++; $display("FAIL w0_regs_at_stb got %h want 00000000a5", stb_regs); end
    checks++; if (stb_cyc - rise_cyc !== SS + 1) begin errors++; $display("FAIL w0_latency got %0d want %0d", stb_cyc - rise_cyc, SS + 1); end
  endtask

  task automatic test_addr_range();
    logic [31:0] rx;
    int s0, e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    spi_xfer(32'h843C, 16, rx);
    checks++; if (regs_flat !== 40'h3C_0000_00A5) begin errors++; $display("FAIL w4_regs got %h want 3c000000a5", regs_flat); end
    checks++; if (stb_addr !== 7'd4) begin errors++; $display("FAIL w4_wr_addr got %h want 4", stb_addr); end
    spi_xfer(32'h87FF, 16, rx);
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL w7_stb_count got %0d want 1", stb_cnt - s0); end
    checks++; if (regs_flat !== 40'h3C_0000_00A5) begin errors++; $display("FAIL w7_regs got %h want 3c000000a5", regs_flat); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL w7_frame_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_bad_length();
    logic [31:0] rx;
    int s0, e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    spi_xfer(32'h40BB, 15, rx);
    spi_xfer(32'h102EE, 17, rx);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL len_frame_err got %0d want 2", err_cnt - e0); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL len_stb_count got %0d want 0", stb_cnt - s0); end
    checks++; if (regs_flat !== 40'h3C_0000_00A5) begin errors++; $display("FAIL len_regs got %h want 3c000000a5", regs_flat); end
  endtask

  task automatic test_empty_frame();
    int s0, e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    @(negedge counter_clock);
    ncs = 1'b0;
    repeat (20) @(negedge counter_clock);
    ncs = 1'b1;
    repeat (12) @(negedge counter_clock);
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL empty_stb_count got %0d want 0", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL empty_frame_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx;
    int s0;
    spi_xfer(32'h8211, 16, rx);
    checks++; if (regs_flat !== 40'h3C_0011_00A5) begin errors++; $display("FAIL w2_regs got %h want 3c001100a5", regs_flat); end
    s0 = stb_cnt;
    @(negedge counter_clock);
    ncs = 1'b0;
    repeat (8) @(negedge counter_clock);
    spi_bits(32'h20, 6, rx);
    rstn = 1'b0;
    repeat (2) @(negedge counter_clock);
    rstn = 1'b1;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL rst_mid_regs got %h want 0", regs_flat); end
    spi_bits(32'h222, 10, rx);
    repeat (8) @(negedge counter_clock);
    ncs = 1'b1;
    repeat (12) @(negedge counter_clock);
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL rst_tail_stb got %0d want 0", stb_cnt - s0); end
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL rst_tail_regs got %h want 0", regs_flat); end
    spi_xfer(32'h8133, 16, rx);
    checks++; if (regs_flat !== 40'h00_0000_3300) begin errors++; $display("FAIL rst_after_regs got %h want 0000003300", regs_flat); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL rst_after_stb got %0d want 1", stb_cnt - s0); end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    logic [31:0] rx;
    int s0, e0;
    spi_xfer(32'h835A, 16, rx);
    checks++; if (regs_flat !== 40'h00_5A00_3300) begin errors++; $display("FAIL rb_w3_regs got %h want 005a003300", regs_flat); end
    s0 = stb_cnt;
    e0 = err_cnt;
    spi_xfer(32'h0300, 16, rx);
    checks++; if (rx[7:0] !== 8'h5A) begin errors++; $display("FAIL rb_data got %h want 5a", rx[7:0]); end
    checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL rb_oe_in_frame got %b want 1", oe_all); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("FAIL rb_oe_after got %b want 0", cipo_oe); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL rb_stb_count got %0d want 0", stb_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rb_frame_err got %0d want 0", err_cnt - e0); end
  endtask
`else
  task automatic test_no_readback();
    logic [31:0] rx;
    int e0;
    e0 = err_cnt;
    spi_xfer(32'h835A, 16, rx);
    spi_xfer(32'h0300, 16, rx);
    checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL nrb_oe got %b want 0", oe_any); end
    checks++; if (cipo_any !== 1'b0) begin errors++; $display("FAIL nrb_cipo got %b want 0", cipo_any); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL nrb_frame_err got %0d want 0", err_cnt - e0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_reg0();
    test_addr_range();
    test_bad_length();
    test_empty_frame();
    test_reset_mid_frame();
`ifdef SPI_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
